// File: rtl/tcam_rule_ctrl_if.sv
// Host-side bundle for tcam_rule_ctrl: rule updates, search requests and search results.
interface tcam_rule_ctrl_if #(
  parameter int KEY_W = 28,
  parameter int IDX_W = 5
);
  logic             upd_valid_i;
  logic             upd_ready_o;
  logic [IDX_W-1:0] upd_entry_i;
  logic             upd_en_i;
  logic [KEY_W-1:0] upd_key_i;
  logic [KEY_W-1:0] upd_care_i;
  logic             srch_valid_i;
  logic             srch_ready_o;
  logic [KEY_W-1:0] srch_key_i;
  logic             rsp_valid_o;
  logic [IDX_W:0]   rsp_index_o;
  logic             init_done_o;

  modport master (
    output upd_valid_i, upd_entry_i, upd_en_i, upd_key_i, upd_care_i, srch_valid_i, srch_key_i,
    input  upd_ready_o, srch_ready_o, rsp_valid_o, rsp_index_o, init_done_o
  );

  modport slave (
    input  upd_valid_i, upd_entry_i, upd_en_i, upd_key_i, upd_care_i, srch_valid_i, srch_key_i,
    output upd_ready_o, srch_ready_o, rsp_valid_o, rsp_index_o, init_done_o
  );
endinterface

// File: rtl/tcam_rule_ctrl.sv
// Rule-table sequencer for an SRAM-based TCAM: clears the arrays after reset, rebuilds all
// match-vector rows on each rule change, and arbitrates searches against pending updates.
module tcam_rule_ctrl #(
  parameter int ENTRIES      = 32,
  parameter int KEY_W        = 28,
  parameter int SRAM_LAT     = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  tcam_rule_ctrl_if.slave            host,
  output logic                       tcam_csb_o,
  output logic                       tcam_web_o,
  output logic [3:0]                 tcam_wmask_o,
  output logic [KEY_W-1:0]           tcam_addr_o,
  output logic [ENTRIES-1:0]         tcam_wdata_o,
  input  logic [$clog2(ENTRIES):0]   tcam_rdata_i
);
  localparam int SLICE_W = KEY_W / 4;
  localparam int CNT_W   = SLICE_W + 2;
  localparam int IDX_W   = $clog2(ENTRIES);
  localparam int STV_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_LAST = '1;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_UPD} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               init_done_q, init_done_d;
  logic [STV_W-1:0]   starve_q, starve_d;
  logic [KEY_W-1:0]   key_q  [ENTRIES];
  logic [KEY_W-1:0]   care_q [ENTRIES];
  logic [ENTRIES-1:0] valid_q;
  logic               csb_q, csb_d, web_q, web_d;
  logic [3:0]         wmask_q, wmask_d;
  logic [KEY_W-1:0]   addr_q, addr_d;
  logic [ENTRIES-1:0] wdata_q, wdata_d, row_word;
  logic [SRAM_LAT:0]  srch_pipe_q;
  logic               rsp_valid_q;
  logic [IDX_W:0]     rsp_index_q;
  logic               arb_en, starved, upd_ready, srch_ready, upd_acc, srch_acc;
  logic [1:0]         vblk;
  logic [SLICE_W-1:0] row_r;

  assign arb_en     = (state_q == S_IDLE) && init_done_q;
  assign starved    = (starve_q >= STV_MAX);
  assign srch_ready = arb_en && !starved;
  assign upd_ready  = arb_en && (starved || !host.srch_valid_i);
  assign upd_acc    = host.upd_valid_i && upd_ready;
  assign srch_acc   = host.srch_valid_i && srch_ready;

  assign host.upd_ready_o  = upd_ready;
  assign host.srch_ready_o = srch_ready;
  assign host.rsp_valid_o  = rsp_valid_q;
  assign host.rsp_index_o  = rsp_index_q;
  assign host.init_done_o  = init_done_q;
  assign tcam_csb_o        = csb_q;
  assign tcam_web_o        = web_q;
  assign tcam_wmask_o      = wmask_q;
  assign tcam_addr_o       = addr_q;
  assign tcam_wdata_o      = wdata_q;

  // Virtual block 0 holds the most significant key slice.
  assign vblk  = cnt_q[CNT_W-1 -: 2];
  assign row_r = cnt_q[SLICE_W-1:0];

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_row
      logic [SLICE_W-1:0] k_sl, c_sl;
      always_comb begin
        case (vblk)
          2'd0: begin
            k_sl = key_q[gi][4*SLICE_W-1 -: SLICE_W];
            c_sl = care_q[gi][4*SLICE_W-1 -: SLICE_W];
          end
          2'd1: begin
            k_sl = key_q[gi][3*SLICE_W-1 -: SLICE_W];
            c_sl = care_q[gi][3*SLICE_W-1 -: SLICE_W];
          end
          2'd2: begin
            k_sl = key_q[gi][2*SLICE_W-1 -: SLICE_W];
            c_sl = care_q[gi][2*SLICE_W-1 -: SLICE_W];
          end
          default: begin
            k_sl = key_q[gi][SLICE_W-1:0];
            c_sl = care_q[gi][SLICE_W-1:0];
          end
        endcase
      end
      assign row_word[gi] = valid_q[gi] & (((row_r ^ k_sl) & c_sl) == '0);
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    starve_d    = starve_q;
    csb_d       = 1'b1;
    web_d       = 1'b1;
    wmask_d     = 4'h0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    case (state_q)
      S_INIT: begin
        csb_d   = 1'b0;
        web_d   = 1'b0;
        wmask_d = 4'hF;
        addr_d  = KEY_W'(cnt_q);
        wdata_d = '0;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_IDLE;
      end
      S_IDLE: begin
        init_done_d = 1'b1;
        if (upd_acc) begin
          state_d  = S_UPD;
          cnt_d    = '0;
          starve_d = '0;
        end else if (host.upd_valid_i && arb_en) begin
          starve_d = starve_q + 1'b1;
        end
        if (srch_acc) begin
          csb_d  = 1'b0;
          addr_d = host.srch_key_i;
        end
      end
      S_UPD: begin
        csb_d   = 1'b0;
        web_d   = 1'b0;
        wmask_d = 4'hF;
        addr_d  = KEY_W'(cnt_q);
        wdata_d = row_word;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      starve_q    <= '0;
      csb_q       <= 1'b1;
      web_q       <= 1'b1;
      wmask_q     <= 4'h0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      starve_q    <= starve_d;
      csb_q       <= csb_d;
      web_q       <= web_d;
      wmask_q     <= wmask_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  // Shadow table is written at the accept edge so the following sweep sees the new rule.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        key_q[i]  <= '0;
        care_q[i] <= '0;
      end
    end else if (upd_acc) begin
      valid_q[host.upd_entry_i] <= host.upd_en_i;
      if (host.upd_en_i) begin
        key_q[host.upd_entry_i]  <= host.upd_key_i;
        care_q[host.upd_entry_i] <= host.upd_care_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      srch_pipe_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_index_q <= '0;
    end else begin
      srch_pipe_q <= {srch_pipe_q[SRAM_LAT-1:0], srch_acc};
      rsp_valid_q <= srch_pipe_q[SRAM_LAT];
      if (srch_pipe_q[SRAM_LAT]) rsp_index_q <= tcam_rdata_i;
    end
  end
endmodule

// File: tb/tb_tcam_rule_ctrl.sv
// Directed bench for tcam_rule_ctrl with a behavioural 2x32x256 TCAM macro model.
module tb_tcam_rule_ctrl;
  localparam logic [27:0] KEY_A = 28'h0ABCDEF;
  localparam logic [27:0] KEY_B = 28'h1234567;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tcam_rule_ctrl_if bus ();
  logic        csb, web;
  logic [3:0]  wmask;
  logic [27:0] addr;
  logic [31:0] wdata;
  logic [5:0]  rdata = '0;

  tcam_rule_ctrl dut (
    .clk_i(clk), .rst_i(rst), .host(bus),
    .tcam_csb_o(csb), .tcam_web_o(web), .tcam_wmask_o(wmask),
    .tcam_addr_o(addr), .tcam_wdata_o(wdata), .tcam_rdata_i(rdata)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] mem [512];

  function automatic logic [5:0] lookup(input logic [27:0] k);
    logic [31:0] v;
    logic [5:0]  r;
    v = mem[{2'd0, k[27:21]}] & mem[{2'd1, k[20:14]}] & mem[{2'd2, k[13:7]}] & mem[{2'd3, k[6:0]}];
    r = '0;
    for (int e = 31; e >= 0; e--) if (v[e]) r = 6'(e + 1);
    return r;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (csb === 1'b0) begin
      if (web === 1'b0) mem[addr[8:0]] <= wdata;
      else rdata <= lookup(addr);
    end
  end

  int          rsp_cyc_q[$];
  logic [5:0]  rsp_idx_q[$];
  logic [31:0] wr_row [512];
  int          wr_n = 0;
  int          wr_first = -1;

  always begin
    @(posedge clk);
    #1;
    if (bus.rsp_valid_o === 1'b1) begin
      rsp_cyc_q.push_back(cyc);
      rsp_idx_q.push_back(bus.rsp_index_o);
    end
    if (csb === 1'b0 && web === 1'b0) begin
      if (wr_n == 0) wr_first = cyc;
      wr_row[addr[8:0]] = wdata;
      wr_n = wr_n + 1;
    end
  end

  task automatic issue_search(input logic [27:0] key, output int acc);
    int n = 0;
    bus.srch_valid_i = 1'b1;
    bus.srch_key_i   = key;
    #1;
    while (bus.srch_ready_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
      #1;
    end
    acc = cyc + 1;
    @(negedge clk);
    bus.srch_valid_i = 1'b0;
  endtask

  task automatic issue_update(input logic [4:0] entry, input logic en, input logic [27:0] key,
                              input logic [27:0] care, output int acc);
    int n = 0;
    bus.upd_valid_i = 1'b1;
    bus.upd_entry_i = entry;
    bus.upd_en_i    = en;
    bus.upd_key_i   = key;
    bus.upd_care_i  = care;
    #1;
    while (bus.upd_ready_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
      #1;
    end
    acc = cyc + 1;
    @(negedge clk);
    bus.upd_valid_i = 1'b0;
    $display("update entry=%0d en=%b key=%h care=%h accepted at edge %0d", entry, en, key, care, acc);
  endtask

  task automatic run_search(input logic [27:0] key, output logic [5:0] idx, output int lat);
    int acc;
    rsp_cyc_q.delete();
    rsp_idx_q.delete();
    issue_search(key, acc);
    repeat (4) @(negedge clk);
    if (rsp_idx_q.size() == 1) begin
      idx = rsp_idx_q[0];
      lat = rsp_cyc_q[0] - acc;
    end else begin
      idx = 6'h3F;
      lat = -1;
    end
    $display("search key=%h index=%0d latency=%0d", key, idx, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (csb !== 1'b1 || web !== 1'b1) begin
      errors++; $display("FAIL reset_csb_web: got csb=%b web=%b, expected 1 1", csb, web);
    end
    checks++;
    if (wmask !== 4'h0 || addr !== 28'h0 || wdata !== 32'h0) begin
      errors++; $display("FAIL reset_bus: got wmask=%h addr=%h wdata=%h, expected 0 0 0", wmask, addr, wdata);
    end
    checks++;
    if (bus.upd_ready_o !== 1'b0 || bus.srch_ready_o !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got upd=%b srch=%b, expected 0 0", bus.upd_ready_o, bus.srch_ready_o);
    end
    checks++;
    if (bus.rsp_valid_o !== 1'b0 || bus.rsp_index_o !== 6'd0 || bus.init_done_o !== 1'b0) begin
      errors++; $display("FAIL reset_rsp: got rsp_valid=%b index=%0d init_done=%b, expected 0 0 0",
                         bus.rsp_valid_o, bus.rsp_index_o, bus.init_done_o);
    end
    $display("reset: outputs sampled");
  endtask

  task automatic test_init();
    int   bad = -1;
    logic [27:0] bad_addr = '0;
    logic rdy_seen = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      if (bad < 0 && (csb !== 1'b0 || web !== 1'b0 || wmask !== 4'hF || addr !== 28'(i) || wdata !== 32'h0)) begin
        bad = i;
        bad_addr = addr;
      end
      if (bus.upd_ready_o !== 1'b0 || bus.srch_ready_o !== 1'b0 || bus.init_done_o !== 1'b0) rdy_seen = 1'b1;
    end
    checks++;
    if (bad >= 0) begin
      errors++; $display("FAIL init_sweep: row %0d got addr=%h, expected a write of 0 to addr %0d", bad, bad_addr, bad);
    end
    checks++;
    if (rdy_seen) begin
      errors++; $display("FAIL init_ready: got ready/init_done high during sweep, expected low");
    end
    @(negedge clk);
    checks++;
    if (bus.init_done_o !== 1'b1) begin
      errors++; $display("FAIL init_done: got %b, expected 1", bus.init_done_o);
    end
    checks++;
    if (csb !== 1'b1 || bus.srch_ready_o !== 1'b1 || bus.upd_ready_o !== 1'b1) begin
      errors++; $display("FAIL init_idle: got csb=%b srch_ready=%b upd_ready=%b, expected 1 1 1",
                         csb, bus.srch_ready_o, bus.upd_ready_o);
    end
    $display("init: sweep of 512 rows observed");
  endtask

  task automatic test_install();
    int acc, lat, ones;
    logic [3:0] hits;
    logic [5:0] idx;
    wr_n = 0;
    issue_update(5'd5, 1'b1, KEY_A, 28'hFFFFFFF, acc);
    repeat (516) @(negedge clk);
    checks++;
    if (wr_n != 512) begin
      errors++; $display("FAIL install_writes: got %0d writes, expected 512", wr_n);
    end
    hits = {wr_row[495][5], wr_row[283][5], wr_row[175][5], wr_row[5][5]};
    checks++;
    if (hits !== 4'hF) begin
      errors++; $display("FAIL install_rows: got bit5 at rows 495/283/175/5 = %b, expected 1111", hits);
    end
    ones = 0;
    for (int r = 0; r < 512; r++) ones += int'(wr_row[r][5]);
    checks++;
    if (ones != 4) begin
      errors++; $display("FAIL install_bit5_count: got %0d rows, expected 4", ones);
    end
    run_search(KEY_A, idx, lat);
    checks++;
    if (lat != 2) begin
      errors++; $display("FAIL search_latency: got %0d, expected 2", lat);
    end
    checks++;
    if (idx !== 6'd6) begin
      errors++; $display("FAIL search_entry5: got index %0d, expected 6", idx);
    end
  endtask

  task automatic test_wildcard();
    int acc, lat, ones;
    logic [5:0] idx;
    wr_n = 0;
    issue_update(5'd3, 1'b1, 28'h5555555, 28'h0, acc);
    repeat (516) @(negedge clk);
    ones = 0;
    for (int r = 0; r < 512; r++) ones += int'(wr_row[r][3]);
    checks++;
    if (wr_n != 512 || ones != 512) begin
      errors++; $display("FAIL wildcard_rows: got %0d writes, %0d rows with bit3, expected 512 512", wr_n, ones);
    end
    run_search(KEY_A, idx, lat);
    checks++;
    if (idx !== 6'd4) begin
      errors++; $display("FAIL wildcard_keyA: got index %0d, expected 4", idx);
    end
    run_search(KEY_B, idx, lat);
    checks++;
    if (idx !== 6'd4) begin
      errors++; $display("FAIL wildcard_keyB: got index %0d, expected 4", idx);
    end
    wr_n = 0;
    issue_update(5'd3, 1'b0, 28'h0, 28'h0, acc);
    repeat (516) @(negedge clk);
    ones = 0;
    for (int r = 0; r < 512; r++) ones += int'(wr_row[r][3]);
    checks++;
    if (ones != 0) begin
      errors++; $display("FAIL delete_rows: got %0d rows with bit3, expected 0", ones);
    end
    run_search(KEY_A, idx, lat);
    checks++;
    if (idx !== 6'd6) begin
      errors++; $display("FAIL delete_keyA: got index %0d, expected 6", idx);
    end
    run_search(KEY_B, idx, lat);
    checks++;
    if (idx !== 6'd0) begin
      errors++; $display("FAIL delete_keyB: got index %0d, expected 0", idx);
    end
  endtask

  task automatic test_starve();
    int n = 0, nsrch = 0, low = 0;
    logic got = 1'b0;
    logic all6 = 1'b1;
    rsp_cyc_q.delete();
    rsp_idx_q.delete();
    wr_n = 0;
    bus.srch_valid_i = 1'b1;
    bus.srch_key_i   = KEY_A;
    bus.upd_valid_i  = 1'b1;
    bus.upd_entry_i  = 5'd7;
    bus.upd_en_i     = 1'b1;
    bus.upd_key_i    = KEY_B;
    bus.upd_care_i   = 28'hFFFFFFF;
    while (!got && n < 20) begin
      n++;
      #1;
      if (bus.upd_ready_o === 1'b1) got = 1'b1;
      else if (bus.srch_ready_o === 1'b1) nsrch++;
      @(negedge clk);
    end
    bus.upd_valid_i = 1'b0;
    $display("starve: update accepted in cycle %0d after %0d searches", n, nsrch);
    checks++;
    if (n != 9) begin
      errors++; $display("FAIL starve_cycle: got cycle %0d, expected 9", n);
    end
    checks++;
    if (nsrch != 8) begin
      errors++; $display("FAIL starve_searches: got %0d searches, expected 8", nsrch);
    end
    #1;
    while (bus.srch_ready_o !== 1'b1 && low < 700) begin
      low++;
      @(negedge clk);
      #1;
    end
    checks++;
    if (low != 512) begin
      errors++; $display("FAIL starve_sweep_block: got %0d cycles srch_ready low, expected 512", low);
    end
    bus.srch_key_i = KEY_B;
    @(negedge clk);
    bus.srch_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8 && i < rsp_idx_q.size(); i++) if (rsp_idx_q[i] !== 6'd6) all6 = 1'b0;
    checks++;
    if (rsp_idx_q.size() != 9 || !all6) begin
      errors++; $display("FAIL starve_inflight: got %0d responses (first eight all 6: %b), expected 9 and 1",
                         rsp_idx_q.size(), all6);
    end
    checks++;
    if (rsp_idx_q.size() == 0 || rsp_idx_q[rsp_idx_q.size()-1] !== 6'd8) begin
      errors++; $display("FAIL starve_resume: got last index %0d, expected 8",
                         (rsp_idx_q.size() == 0) ? 6'd0 : rsp_idx_q[rsp_idx_q.size()-1]);
    end
    checks++;
    if (wr_n != 512) begin
      errors++; $display("FAIL starve_writes: got %0d writes, expected 512", wr_n);
    end
  endtask

  task automatic test_back_to_back();
    int   a;
    logic ok1, ok2, ok3;
    rsp_cyc_q.delete();
    rsp_idx_q.delete();
    bus.srch_valid_i = 1'b1;
    bus.srch_key_i   = KEY_A;
    #1;
    a   = cyc + 1;
    ok1 = bus.srch_ready_o;
    @(negedge clk);
    bus.srch_key_i = KEY_B;
    #1;
    ok2 = bus.srch_ready_o;
    @(negedge clk);
    bus.srch_valid_i = 1'b0;
    bus.upd_valid_i  = 1'b1;
    bus.upd_entry_i  = 5'd9;
    bus.upd_en_i     = 1'b0;
    wr_n     = 0;
    wr_first = -1;
    #1;
    ok3 = bus.upd_ready_o;
    @(negedge clk);
    bus.upd_valid_i = 1'b0;
    repeat (516) @(negedge clk);
    $display("b2b: searches at edges %0d,%0d, update at %0d, %0d responses, first write at %0d",
             a, a + 1, a + 2, rsp_idx_q.size(), wr_first);
    checks++;
    if (ok1 !== 1'b1 || ok2 !== 1'b1 || ok3 !== 1'b1) begin
      errors++; $display("FAIL b2b_ready: got %b%b%b, expected 111", ok1, ok2, ok3);
    end
    checks++;
    if (rsp_cyc_q.size() != 2 || rsp_cyc_q[0] != a + 2 || rsp_cyc_q[1] != a + 3) begin
      errors++; $display("FAIL b2b_rsp_timing: got %0d pulses, expected 2 at edges %0d and %0d",
                         rsp_cyc_q.size(), a + 2, a + 3);
    end
    checks++;
    if (rsp_idx_q.size() != 2 || rsp_idx_q[0] !== 6'd6 || rsp_idx_q[1] !== 6'd8) begin
      errors++; $display("FAIL b2b_rsp_index: got %0d responses, expected indices 6 then 8", rsp_idx_q.size());
    end
    checks++;
    if (wr_first != a + 3 || wr_n != 512) begin
      errors++; $display("FAIL b2b_sweep_start: got first write at %0d with %0d writes, expected %0d and 512",
                         wr_first, wr_n, a + 3);
    end
  endtask

  task automatic test_reset_mid_upd();
    int acc, lat;
    int n = 0;
    logic [5:0] idx;
    issue_update(5'd2, 1'b1, 28'h7777777, 28'hFFFFFFF, acc);
    while (!(csb === 1'b0 && web === 1'b0 && addr === 28'd200) && n < 600) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 600) begin
      errors++; $display("FAIL midupd_row200: got no write to row 200, expected one");
    end
    rst = 1'b1;
    #1;
    checks++;
    if (csb !== 1'b1 || web !== 1'b1 || wmask !== 4'h0 || addr !== 28'h0 || wdata !== 32'h0) begin
      errors++; $display("FAIL midupd_reset_bus: got csb=%b web=%b wmask=%h addr=%h wdata=%h, expected 1 1 0 0 0",
                         csb, web, wmask, addr, wdata);
    end
    checks++;
    if (bus.upd_ready_o !== 1'b0 || bus.srch_ready_o !== 1'b0 || bus.init_done_o !== 1'b0 || bus.rsp_index_o !== 6'd0) begin
      errors++; $display("FAIL midupd_reset_host: got upd=%b srch=%b init_done=%b index=%0d, expected 0 0 0 0",
                         bus.upd_ready_o, bus.srch_ready_o, bus.init_done_o, bus.rsp_index_o);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (csb !== 1'b0 || web !== 1'b0 || addr !== 28'h0 || wdata !== 32'h0) begin
      errors++; $display("FAIL midupd_init_restart: got csb=%b web=%b addr=%h wdata=%h, expected 0 0 0 0",
                         csb, web, addr, wdata);
    end
    n = 0;
    while (bus.init_done_o !== 1'b1 && n < 700) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.init_done_o !== 1'b1) begin
      errors++; $display("FAIL midupd_init_done: got %b, expected 1", bus.init_done_o);
    end
    run_search(KEY_A, idx, lat);
    checks++;
    if (idx !== 6'd0) begin
      errors++; $display("FAIL midupd_miss: got index %0d, expected 0", idx);
    end
  endtask

  initial begin
    bus.upd_valid_i  = 1'b0;
    bus.upd_entry_i  = '0;
    bus.upd_en_i     = 1'b0;
    bus.upd_key_i    = '0;
    bus.upd_care_i   = '0;
    bus.srch_valid_i = 1'b0;
    bus.srch_key_i   = '0;
    #1;
    test_reset();
    test_init();
    test_install();
    test_wildcard();
    test_starve();
    test_back_to_back();
    test_reset_mid_upd();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/tcam_rule_ctrl.md
Name: tcam_rule_ctrl

Overview:
- Sequencing controller in front of the 32-entry x 28-bit SRAM-based TCAM macro (two 32x256 dual-port SRAMs; four 7-bit virtual blocks).
- Keeps a shadow rule table of 32 ternary entries (key, care mask, valid). On every rule install or delete it regenerates all 512 SRAM match-vector rows.
- Arbitrates the single TCAM port between rule updates and search requests, and clears the arrays after reset.

Parameters:
- ENTRIES, 32, number of TCAM entries; equals the SRAM word width.
- KEY_W, 28, search key width; 4 slices of 7 bits.
- SRAM_LAT, 1, cycles from the TCAM op cycle to a valid tcam_rdata_i.
- STARVE_LIMIT, 8, consecutive cycles a pending update may lose arbitration before it takes priority.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  asynchronous, active-high reset.
- upd_valid_i  in  1  rule update request.
- upd_ready_o  out  1  update accepted when valid and ready are both high.
- upd_entry_i  in  5  entry index 0..31; lower index has higher match priority.
- upd_en_i  in  1  1 = install or overwrite entry; 0 = delete (valid cleared).
- upd_key_i  in  28  rule key.
- upd_care_i  in  28  care mask; bit 0 = don't-care.
- srch_valid_i  in  1  search request.
- srch_ready_o  out  1  search accepted when valid and ready are both high.
- srch_key_i  in  28  search key.
- rsp_valid_o  out  1  one-cycle search-result strobe.
- rsp_index_o  out  6  matching entry + 1; 0 = miss.
- init_done_o  out  1  high once the post-reset clear sweep has completed.
- tcam_csb_o  out  1  TCAM chip select, active low.
- tcam_web_o  out  1  TCAM write enable, active low.
- tcam_wmask_o  out  4  TCAM byte write mask.
- tcam_addr_o  out  28  TCAM address / search query.
- tcam_wdata_o  out  32  TCAM write data (row match vector).
- tcam_rdata_i  in  6  TCAM priority-encoded result.

Behaviour:
- Reset values: upd_ready_o=0, srch_ready_o=0, rsp_valid_o=0, rsp_index_o=0, init_done_o=0, tcam_csb_o=1, tcam_web_o=1, tcam_wmask_o=0, tcam_addr_o=0, tcam_wdata_o=0. Shadow valid bits all 0; FSM in INIT with row counter 0.
- All tcam_* outputs are registered. An op decided at edge E appears on the pins for the cycle E..E+1.
- Row counter cnt[8:0] maps to the TCAM write address as follows:
  - cnt[8] = SRAM select (TCAM addr bit 8).
  - cnt[7] = upper half; vtb2 and vtb4 occupy rows 128-255.
  - cnt[6:0] = row value r.
  - tcam_addr_o = {19'b0, cnt}.
- Virtual block v = cnt[8:7]. Key slices by v:
  - v=0: key[27:21]
  - v=1: key[20:14]
  - v=2: key[13:7]
  - v=3: key[6:0]
- Row word: wdata[e] = valid[e] & (((r ^ key_e_slice) & care_e_slice) == 0). Every write uses wmask=4'hF, csb=0, web=0.
- FSM states:
  - INIT: writes wdata=0 to rows 0..511, one row per cycle, no handshakes. After row 511 it goes to IDLE and sets init_done_o=1 (it stays 1 until reset).
  - IDLE: upd_ready_o=1 and srch_ready_o=1, subject to arbitration.
  - UPD: 512 consecutive row writes, cnt 0..511. Both ready outputs are 0. Returns to IDLE after cnt=511.
- Update acceptance:
  - The shadow entry is written at the accept edge, so the sweep uses the new value.
  - Delete clears valid only.
  - Overwriting a valid entry replaces key and care.
- Search acceptance: in IDLE, drive csb=0, web=1, addr=srch_key_i, wmask=0. Searches may be accepted back-to-back, one per cycle.
- Search response:
  - tcam_rdata_i is sampled SRAM_LAT cycles after the op cycle.
  - rsp_valid_o is high for exactly one cycle and rsp_index_o holds the sample; rsp_index_o keeps its value otherwise.
  - Default latency: accept at edge 0, rsp_valid_o high between edges 2 and 3.
  - There is no response backpressure.
- Arbitration in IDLE:
  - With no pending update, search wins.
  - A starvation counter increments for each cycle in which upd_valid_i is high and the update is not accepted.
  - When the counter reaches STARVE_LIMIT, srch_ready_o=0 and upd_ready_o=1. The counter clears on update accept.
  - With the default STARVE_LIMIT=8, an update under continuous search load is accepted on the 9th cycle.
- In-flight searches at update accept still deliver their response at the normal latency. The response pipeline is independent of the FSM.
- Idle cycles: csb=1, web=1.
- A reset asserted mid-UPD or mid-INIT aborts the sweep immediately: shadow table cleared, outputs at reset values, INIT restarts on deassertion.
- Update and search requests are ignored (ready=0) while init_done_o=0.

Test Plan:
- Reset release -> 512 write cycles with tcam_addr_o 0..511, wdata=0, wmask=F; init_done_o rises the cycle after row 511; no ready before that.
- Install entry 5, key=28'h0ABCDEF, care=all-ones -> 512 writes. Row (v=0, r=key[27:21]) has wdata bit5=1; every other row in that block has bit5=0. Search 28'h0ABCDEF then gives rsp_index_o=6 in cycle 2 after accept.
- Install entry 3, care=0 (wildcard) -> every row has bit3=1. Any search returns 4 while entry 3 is the lowest-index valid entry. Delete entry 3 -> the same search returns 6.
- srch_valid_i held high continuously while upd_valid_i is asserted -> update accepted on the 9th cycle; srch_ready_o low for the 512-cycle sweep; searches resume afterwards.
- Two back-to-back searches accepted, then an update accepted the next cycle -> two rsp_valid_o pulses on consecutive cycles at normal latency; sweep starts without delay.
- rst_i asserted at UPD cnt=200 -> outputs at reset values immediately; INIT sweep restarts from row 0; a prior installed entry searches as miss (index 0).
